// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one add/nand ALU through a round-robin grant.
// Each requester's result is held in its own slot until that requester accepts it.
// Define ALU_ARB_STATS_EN to add grant and conflict statistics counters.
module alu_arbiter #(
  parameter int unsigned p_WORD_LEN = 16,
  parameter int unsigned p_CNT_LEN  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_op,
  input  logic [p_WORD_LEN-1:0] i_req0_a,
  input  logic [p_WORD_LEN-1:0] i_req0_b,
  output logic                  o_rsp0_valid,
  input  logic                  i_rsp0_ready,
  output logic [p_WORD_LEN-1:0] o_rsp0_out,
  output logic                  o_rsp0_eq,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_op,
  input  logic [p_WORD_LEN-1:0] i_req1_a,
  input  logic [p_WORD_LEN-1:0] i_req1_b,
  output logic                  o_rsp1_valid,
  input  logic                  i_rsp1_ready,
  output logic [p_WORD_LEN-1:0] o_rsp1_out,
  output logic                  o_rsp1_eq
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [p_CNT_LEN-1:0]  o_gnt0_cnt,
  output logic [p_CNT_LEN-1:0]  o_gnt1_cnt,
  output logic [p_CNT_LEN-1:0]  o_conflict_cnt
`endif
);

  typedef struct packed {
    logic                  op;
    logic [p_WORD_LEN-1:0] a;
    logic [p_WORD_LEN-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [p_WORD_LEN-1:0] out;
    logic                  eq;
  } alu_rsp_t;

  typedef enum logic {
    PTR_P0 = 1'b0,
    PTR_P1 = 1'b1
  } ptr_e;

  if (p_CNT_LEN < 1) begin : g_cnt_len_chk
    $error("p_CNT_LEN must be at least 1");
  end

  ptr_e                  r_ptr;
  ptr_e                  w_ptr_nxt;
  logic                  w_free0;
  logic                  w_free1;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  alu_req_t              w_req0;
  alu_req_t              w_req1;
  alu_req_t              w_alu_req;
  alu_rsp_t              w_alu_rsp;
  logic [p_WORD_LEN-1:0] w_sum;

  logic                  r_rsp0_valid;
  logic [p_WORD_LEN-1:0] r_rsp0_out;
  logic                  r_rsp0_eq;
  logic                  r_rsp1_valid;
  logic [p_WORD_LEN-1:0] r_rsp1_out;
  logic                  r_rsp1_eq;

  // Priority pointer register: names the port that wins a tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= PTR_P0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Eligibility, grant and next pointer; a slot draining this cycle can refill.
  always_comb begin
    w_free0   = 1'b0;
    w_free1   = 1'b0;
    w_elig0   = 1'b0;
    w_elig1   = 1'b0;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_ptr_nxt = r_ptr;

    w_free0 = !r_rsp0_valid || i_rsp0_ready;
    w_free1 = !r_rsp1_valid || i_rsp1_ready;
    w_elig0 = !i_rst && i_req0_valid && w_free0;
    w_elig1 = !i_rst && i_req1_valid && w_free1;
    w_gnt0  = w_elig0 && (!w_elig1 || (r_ptr == PTR_P0));
    w_gnt1  = w_elig1 && (!w_elig0 || (r_ptr == PTR_P1));

    if (w_gnt0) begin
      w_ptr_nxt = PTR_P1;
    end else if (w_gnt1) begin
      w_ptr_nxt = PTR_P0;
    end
  end

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  assign w_req0 = '{op: i_req0_op, a: i_req0_a, b: i_req0_b};
  assign w_req1 = '{op: i_req1_op, a: i_req1_a, b: i_req1_b};

  // Shared ALU; port 0 feeds it when nobody is granted and the result is dropped.
  always_comb begin
    w_alu_req     = w_gnt1 ? w_req1 : w_req0;
    w_sum         = w_alu_req.a + w_alu_req.b;
    w_alu_rsp.out = w_alu_req.op ? ~(w_alu_req.a & w_alu_req.b) : w_sum;
    w_alu_rsp.eq  = (w_alu_req.a == w_alu_req.b);
  end

  // Port 0 response slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_out   <= '0;
      r_rsp0_eq    <= 1'b0;
    end else if (w_gnt0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_out   <= w_alu_rsp.out;
      r_rsp0_eq    <= w_alu_rsp.eq;
    end else if (i_rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  // Port 1 response slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_out   <= '0;
      r_rsp1_eq    <= 1'b0;
    end else if (w_gnt1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_out   <= w_alu_rsp.out;
      r_rsp1_eq    <= w_alu_rsp.eq;
    end else if (i_rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp0_out   = r_rsp0_out;
  assign o_rsp0_eq    = r_rsp0_eq;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp1_out   = r_rsp1_out;
  assign o_rsp1_eq    = r_rsp1_eq;

`ifdef ALU_ARB_STATS_EN
  logic [p_CNT_LEN-1:0] r_gnt0_cnt;
  logic [p_CNT_LEN-1:0] r_gnt1_cnt;
  logic [p_CNT_LEN-1:0] r_conflict_cnt;

  // Free-running wrap-around statistics.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt0_cnt     <= '0;
      r_gnt1_cnt     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt0) begin
        r_gnt0_cnt <= r_gnt0_cnt + p_CNT_LEN'(1);
      end
      if (w_gnt1) begin
        r_gnt1_cnt <= r_gnt1_cnt + p_CNT_LEN'(1);
      end
      if (w_elig0 && w_elig1) begin
        r_conflict_cnt <= r_conflict_cnt + p_CNT_LEN'(1);
      end
    end
  end

  assign o_gnt0_cnt     = r_gnt0_cnt;
  assign o_gnt1_cnt     = r_gnt1_cnt;
  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by constrained-random traffic.
module tb_alu_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [W-1:0] out;
    logic         eq;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         req_valid [2];
  logic         req_op    [2];
  logic [W-1:0] req_a     [2];
  logic [W-1:0] req_b     [2];
  logic         rsp_ready [2];

  logic         o_req0_ready, o_req1_ready;
  logic         o_rsp0_valid, o_rsp1_valid;
  logic [W-1:0] o_rsp0_out, o_rsp1_out;
  logic         o_rsp0_eq, o_rsp1_eq;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] o_gnt0_cnt, o_gnt1_cnt, o_conflict_cnt;
  int            m_g0, m_g1, m_cf;
`endif

  int   n_cmp;
  int   n_err;
  exp_t q0[$];
  exp_t q1[$];
  bit   m_busy [2];
  int   m_ptr;

  alu_arbiter #(.p_WORD_LEN(W), .p_CNT_LEN(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req_valid[0]), .o_req0_ready(o_req0_ready), .i_req0_op(req_op[0]),
    .i_req0_a(req_a[0]), .i_req0_b(req_b[0]),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(rsp_ready[0]),
    .o_rsp0_out(o_rsp0_out), .o_rsp0_eq(o_rsp0_eq),
    .i_req1_valid(req_valid[1]), .o_req1_ready(o_req1_ready), .i_req1_op(req_op[1]),
    .i_req1_a(req_a[1]), .i_req1_b(req_b[1]),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(rsp_ready[1]),
    .o_rsp1_out(o_rsp1_out), .o_rsp1_eq(o_rsp1_eq)
`ifdef ALU_ARB_STATS_EN
    ,
    .o_gnt0_cnt(o_gnt0_cnt), .o_gnt1_cnt(o_gnt1_cnt), .o_conflict_cnt(o_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t alu_ref(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int unsigned s;
    s     = (int'(a) + int'(b)) % (1 << W);
    e.out = op ? ~(a & b) : W'(s);
    e.eq  = (a == b);
    return e;
  endfunction

  // Reference model: slot occupancy and tie-break pointer, evaluated once per cycle.
  always @(negedge clk) begin : p_model
    bit elig [2];
    bit gnt  [2];
    if (rst) begin
      check("rst_ready0", 32'(o_req0_ready), 32'd0);
      check("rst_ready1", 32'(o_req1_ready), 32'd0);
      check("rst_valid0", 32'(o_rsp0_valid), 32'd0);
      check("rst_valid1", 32'(o_rsp1_valid), 32'd0);
      check("rst_out0", 32'(o_rsp0_out), 32'd0);
      check("rst_out1", 32'(o_rsp1_out), 32'd0);
      m_busy[0] = 0;
      m_busy[1] = 0;
      m_ptr = 0;
      q0.delete();
      q1.delete();
`ifdef ALU_ARB_STATS_EN
      m_g0 = 0; m_g1 = 0; m_cf = 0;
      check("rst_gnt0_cnt", 32'(o_gnt0_cnt), 32'd0);
`endif
    end else begin
      for (int n = 0; n < 2; n++) begin
        elig[n] = req_valid[n] && (!m_busy[n] || rsp_ready[n]);
        gnt[n]  = 0;
      end
      if (elig[0] && elig[1]) gnt[m_ptr] = 1;
      else begin
        gnt[0] = elig[0];
        gnt[1] = elig[1];
      end
      check("ready0", 32'(o_req0_ready), 32'(gnt[0]));
      check("ready1", 32'(o_req1_ready), 32'(gnt[1]));
      check("valid0", 32'(o_rsp0_valid), 32'(m_busy[0]));
      check("valid1", 32'(o_rsp1_valid), 32'(m_busy[1]));
`ifdef ALU_ARB_STATS_EN
      check("gnt0_cnt", 32'(o_gnt0_cnt), 32'(CW'(m_g0)));
      check("gnt1_cnt", 32'(o_gnt1_cnt), 32'(CW'(m_g1)));
      check("conflict_cnt", 32'(o_conflict_cnt), 32'(CW'(m_cf)));
      if (gnt[0]) m_g0++;
      if (gnt[1]) m_g1++;
      if (elig[0] && elig[1]) m_cf++;
`endif
      if (gnt[0]) q0.push_back(alu_ref(req_op[0], req_a[0], req_b[0]));
      if (gnt[1]) q1.push_back(alu_ref(req_op[1], req_a[1], req_b[1]));
      for (int n = 0; n < 2; n++) begin
        if (gnt[n]) m_busy[n] = 1;
        else if (rsp_ready[n]) m_busy[n] = 0;
      end
      if (gnt[0]) m_ptr = 1;
      else if (gnt[1]) m_ptr = 0;
    end
  end

  // Monitor: every accepted response is popped and compared in order.
  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (!rst && o_rsp0_valid && rsp_ready[0]) begin
      if (q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("rsp0_out", 32'(o_rsp0_out), 32'(e.out));
        check("rsp0_eq", 32'(o_rsp0_eq), 32'(e.eq));
      end
    end
    if (!rst && o_rsp1_valid && rsp_ready[1]) begin
      if (q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("rsp1_out", 32'(o_rsp1_out), 32'(e.out));
        check("rsp1_eq", 32'(o_rsp1_eq), 32'(e.eq));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    req_valid[p] = v;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
  endtask

  initial begin : p_stim
    bit hs [2];
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      drive(n, 1'b0, 1'b0, '0, '0);
      rsp_ready[n] = 1'b0;
    end
    cyc(); cyc();
    rst = 1'b0;

    // Single add with carry out of bit 14.
    drive(0, 1'b1, 1'b0, 16'h7FFF, 16'h0001);
    #1 check("add_ready0", 32'(o_req0_ready), 32'd1);
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    check("add_valid0", 32'(o_rsp0_valid), 32'd1);
    check("add_out0", 32'(o_rsp0_out), 32'h8000);
    check("add_eq0", 32'(o_rsp0_eq), 32'd0);
    rsp_ready[0] = 1'b1;

    // Wrapping add then nand on port 1.
    drive(1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    cyc();
    drive(1, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    #1;
    check("wrap_out1", 32'(o_rsp1_out), 32'hFFFE);
    check("wrap_eq1", 32'(o_rsp1_eq), 32'd1);
    rsp_ready[1] = 1'b1;
    cyc();
    drive(1, 1'b0, 1'b0, '0, '0);
    #1 check("nand_out1", 32'(o_rsp1_out), 32'h0FFF);

    // Continuous dual requests alternate grants.
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0020);
    drive(1, 1'b1, 1'b1, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_ready0", 32'(o_req0_ready), 32'((i % 2) == 0));
      check("alt_ready1", 32'(o_req1_ready), 32'((i % 2) == 1));
      cyc();
    end
    drive(1, 1'b0, 1'b0, '0, '0);

    // Back-pressure on port 0 while port 1 keeps being served.
    drive(0, 1'b1, 1'b0, 16'h1230, 16'h0004);
    cyc();
    rsp_ready[0] = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h0101, 16'h0202);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", 32'(o_req0_ready), 32'd0);
      check("bp_ready1", 32'(o_req1_ready), 32'd1);
      check("bp_out0", 32'(o_rsp0_out), 32'h1234);
      cyc();
    end
    rsp_ready[0] = 1'b1;
    #1;
    check("bp_release_ready0", 32'(o_req0_ready), 32'd1);
    check("bp_release_ready1", 32'(o_req1_ready), 32'd0);
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    cyc();

    // Leave rsp1 pending and pointer favouring port 1, then reset asynchronously.
    rsp_ready[1] = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h4444, 16'h1111);
    cyc();
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b1, 1'b1, 16'h00AA, 16'h00AA);
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    #1 check("pre_rst_valid1", 32'(o_rsp1_valid), 32'd1);
    #1;
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h0003, 16'h0004);
    drive(1, 1'b1, 1'b0, 16'h0005, 16'h0006);
    #1;
    check("async_rst_valid1", 32'(o_rsp1_valid), 32'd0);
    check("async_rst_out1", 32'(o_rsp1_out), 32'd0);
    check("rst_no_accept0", 32'(o_req0_ready), 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    #1;
    check("post_rst_ready0", 32'(o_req0_ready), 32'd1);
    check("post_rst_ready1", 32'(o_req1_ready), 32'd0);
    cyc();

    // Random traffic; requesters hold valid and operands until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs[0] = req_valid[0] && o_req0_ready;
      hs[1] = req_valid[1] && o_req1_ready;
      cyc();
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n] || hs[n]) begin
          req_valid[n] = ($urandom_range(0, 9) < 6);
          req_op[n]    = 1'($urandom_range(0, 1));
          req_a[n]     = W'($urandom);
          req_b[n]     = ($urandom_range(0, 7) == 0) ? req_a[n] : W'($urandom);
        end
        rsp_ready[n] = ($urandom_range(0, 9) < 7);
      end
    end

    // Drain: everything granted must have been delivered.
    @(negedge clk);
    hs[0] = req_valid[0] && o_req0_ready;
    hs[1] = req_valid[1] && o_req1_ready;
    cyc();
    for (int n = 0; n < 2; n++) begin
      if (hs[n]) req_valid[n] = 1'b0;
      rsp_ready[n] = 1'b1;
    end
    for (int i = 0; i < 20 && (req_valid[0] || req_valid[1]); i++) begin
      @(negedge clk);
      hs[0] = req_valid[0] && o_req0_ready;
      hs[1] = req_valid[1] && o_req1_ready;
      cyc();
      for (int n = 0; n < 2; n++) if (hs[n]) req_valid[n] = 1'b0;
    end
    check("drain_valid0_low", 32'(req_valid[0]), 32'd0);
    check("drain_valid1_low", 32'(req_valid[1]), 32'd0);
    repeat (4) cyc();
    check("drain_q0_empty", 32'(q0.size()), 32'd0);
    check("drain_q1_empty", 32'(q1.size()), 32'd0);
    check("drain_valid0", 32'(o_rsp0_valid), 32'd0);
    check("drain_valid1", 32'(o_rsp1_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one add/nand ALU (16-bit word) between two requesters, e.g. the execute stage (port 0) and a debug/branch-target unit (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, with at most one ALU operation per cycle.
- The block instantiates the ALU internally and registers each requester's result until that requester accepts it.

Parameters:
- p_WORD_LEN, 16, operand/result width.
- p_CNT_LEN, 16, width of the statistics counters (used only with ALU_ARB_STATS_EN).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req0_valid  in  1  requester 0 has an operation.
- o_req0_ready  out  1  requester 0's operation is accepted this cycle.
- i_req0_op  in  1  0 = add, 1 = nand.
- i_req0_a  in  p_WORD_LEN  operand a.
- i_req0_b  in  p_WORD_LEN  operand b.
- o_rsp0_valid  out  1  result pending for requester 0.
- i_rsp0_ready  in  1  requester 0 consumes the result.
- o_rsp0_out  out  p_WORD_LEN  result.
- o_rsp0_eq  out  1  operands were equal.
- i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b, o_rsp1_valid, i_rsp1_ready, o_rsp1_out, o_rsp1_eq: identical to the port-0 set, for requester 1.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - o_rspN_valid=0, o_rspN_out=0, o_rspN_eq=0.
  - Priority pointer = 0 (port 0 favoured).
  - Counters = 0.
  - A reset during a pending response drops that response; a request presented during reset is not accepted.
- Eligibility:
  - Port N is eligible when i_reqN_valid=1 and its response slot is free.
  - Slot free means o_rspN_valid=0, or o_rspN_valid=1 and i_rspN_ready=1 in the same cycle (drain-and-refill).
- Grant (combinational, same cycle):
  - Exactly one port wins: only one eligible, it wins; both eligible, the pointer's port wins.
  - o_reqN_ready=1 only for the winner.
  - o_reqN_ready never depends on i_reqN_valid of the same port through the pointer; it depends only on eligibility.
- ALU input mux: selects the winner's op/a/b. With no winner, the mux holds port 0's inputs and the result is discarded.
- Accept (rising edge with a grant):
  - The winner's o_rspN_out/o_rspN_eq load the ALU output.
  - add = (a+b) mod 2^p_WORD_LEN, carry discarded.
  - nand = ~(a&b).
  - eq = (a==b).
  - o_rspN_valid is set.
- Latency: request accepted at edge t, response visible after edge t; issue is one cycle.
- Response hold:
  - While o_rspN_valid=1 and i_rspN_ready=0, out/eq/valid stay stable.
  - On i_rspN_ready=1 with no new grant to N, o_rspN_valid clears at the edge.
- Pointer:
  - After any grant, the pointer moves to the loser (the non-granted port).
  - With no grant, the pointer is unchanged.
  - Under continuous dual requests, grants strictly alternate 0,1,0,1…
- Other port: a stalled response on one port never blocks the other port.
- Requester obligations: requesters keep valid and operands stable until ready. The arbiter does not check this.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, three extra outputs are added, each p_CNT_LEN wide:
  - o_gnt0_cnt: grants to port 0.
  - o_gnt1_cnt: grants to port 1.
  - o_conflict_cnt: cycles where both ports were eligible.
- The counters increment at the edge, wrap modulo 2^p_CNT_LEN, and are cleared by i_rst.
- When not defined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- Single add: reset, then req0 op=0, a=16'h7FFF, b=16'h0001 → ready0=1 in the same cycle; next cycle rsp0_valid=1, out=16'h8000, eq=0.
- Wrap and nand: req1 op=0, a=b=16'hFFFF → out=16'hFFFE, eq=1. Then op=1, a=16'hF0F0, b=16'hFF00 → out=16'h0FFF.
- Contention: both valid for 4 cycles, both rsp_ready=1 → grants 0,1,0,1; each port sees 2 responses in order.
- Back-pressure: rsp0_ready=0 with a pending result 16'h1234, req0 and req1 both valid → ready0=0, port 1 served every cycle, rsp0 held at 16'h1234. Then rsp0_ready=1 → port 0 is granted again in the same cycle.
- Reset mid-operation: assert i_rst with rsp1_valid=1 → rsp1_valid=0 and out=0 immediately, without waiting for a clock edge; pointer back to 0, so the next dual request grants port 0.
- Stats (ALU_ARB_STATS_EN): 6 dual-request cycles → gnt0=3, gnt1=3, conflict=6; with p_CNT_LEN=2, gnt0 after 5 grants reads 1.
